// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding, data width and the oversample divider helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Rounded clocks-per-tick for a given line rate and oversample factor.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream: single-entry valid/ready byte plus one-cycle error pulses.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] data;
  logic                   valid;
  logic                   ready;
  logic                   frame_err;
  logic                   overrun;

  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Divider emitting a one-cycle tick_o every DIV enabled clocks; clear or disable parks it at 0.
// Latency: first tick DIV clocks after enable with a cleared count; no backpressure.
module uart_baud_tick #(
  parameter int unsigned DIV = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronized rx_i, 16x oversampled start/data/stop, byte into a one-entry valid/ready register.
// Byte or frame_err appears one clock after the mid-stop sample; a byte finding the register full is dropped with overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_i,
  uart_rx_if.master out_if
);

  localparam int unsigned   DIV       = uart_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned   TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_W - 1);

  logic rx_meta_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) {rx_meta_q, rx_s_q, rx_prev_q} <= 3'b111;
    else     {rx_meta_q, rx_s_q, rx_prev_q} <= {rx_i, rx_meta_q, rx_s_q};
  end

  uart_state_e            state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tick, start_edge, byte_done, frame_err;

  // A falling edge needs a previously-high line, so a held break never restarts a frame.
  assign start_edge = rx_prev_q & ~rx_s_q;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  ((state_q == IDLE) && start_edge),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d    = START;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
      START: if (tick) begin
        if (tick_cnt_q == MID_TICK) begin
          tick_cnt_d = '0;
          state_d    = rx_s_q ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      DATA: if (tick) begin
        if (tick_cnt_q == LAST_TICK) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s_q, shift_q[UART_DATA_W-1:1]};
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      STOP: if (tick) begin
        if (tick_cnt_q == LAST_TICK) begin
          tick_cnt_d = '0;
          state_d    = IDLE;
          byte_done  = rx_s_q;
          frame_err  = ~rx_s_q;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  logic [UART_DATA_W-1:0] data_q;
  logic                   valid_q, frame_err_q, overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err;
      overrun_q   <= 1'b0;
      if (byte_done) begin
        if (!valid_q || out_if.ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.data      = data_q;
  assign out_if.valid     = valid_q;
  assign out_if.frame_err = frame_err_q;
  assign out_if.overrun   = overrun_q;

endmodule
